mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter_pkg.sv | 23 ++
 rtl/mux4_rr_arbiter_mux4in.sv | 12 +
 rtl/mux4_rr_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// Also holds the round-robin pick helper used by the arbiter FSM.
package mux4_rr_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Scan last+1, last+2, last+3, last (mod 4). The first requester found wins.
    // The loop runs backwards, so the nearest set index is written last and takes effect.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4in.sv
// Shared 4:1 single-bit data mux that the arbiter drives.
module mux4in
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] in,
    input  logic [1:0]      sel,
    output logic            out
);

    assign out = in[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux.
// Grants are registered and one-hot, and each tenure lasts at most HOLD_CYCLES cycles.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            busy,
    output logic            out
);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       ptr;
    logic [1:0]       pick;
    logic             release_now;
    logic             mux_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            count_q <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // While a grant is active, the current owner is the pointer, so it is scanned last on release.
    assign ptr  = (state_q == GRANT) ? sel_q : last_q;
    assign pick = rr_pick(req, ptr);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        count_d     = count_q;
        last_d      = last_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    count_d = '0;
                end
            end
            GRANT: begin
                release_now = !req[sel_q] || (count_q == CNT_W'(HOLD_CYCLES - 1));
                if (release_now) begin
                    last_d = sel_q;
                    if (|req) begin
                        sel_d   = pick;
                        gnt_d   = NREQ'(1) << pick;
                        count_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    mux4in u_mux (
        .in  (in),
        .sel (sel_q),
        .out (mux_raw)
    );

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);
    assign out  = mux_raw & busy;

endmodule
